imm_extend_pipe: RTL and testbench
==================================

Name: imm_extend_pipe

Overview:
Parametrised, registered immediate-extension stage for the MIPS datapath. It widens an IMM_WIDTH immediate to DATA_WIDTH in one of four modes: sign, zero, upper (LUI) or branch-offset (sign-extend then shift). The block sits between the decode and execute pipeline stages. It has a valid/ready handshake on both sides and a 2-entry skid buffer, so execute-stage stalls never drop or duplicate an immediate.

Parameters:
DATA_WIDTH, 32, width of the extended output word
IMM_WIDTH, 16, width of the incoming immediate field; legal range 1..DATA_WIDTH-1
BR_SHIFT, 2, left-shift amount applied in branch mode; legal range 0..DATA_WIDTH-IMM_WIDTH

Ports:
clk  input  1  rising-edge clock for all state
rst  input  1  asynchronous reset, active-high
in_valid  input  1  upstream presents immediate and mode
in_ready  output  1  block can accept an input this cycle
immediate  input  IMM_WIDTH  raw immediate field
mode  input  2  00 sign, 01 zero, 10 upper, 11 branch
out_valid  output  1  addr holds a valid result
out_ready  input  1  downstream consumes addr this cycle
addr  output  DATA_WIDTH  extended result
out_mode  output  2  mode that produced the current addr

Behaviour:
- Clocking and reset: one clock, clk. rst is asynchronous and active-high.
- While rst is high, and on the first edge after it falls: out_valid=0, addr=0, out_mode=00, skid entry cleared, state=EMPTY, in_ready=1.
- Reset asserted mid-operation discards every held entry immediately. No partial output is produced.
- Accept event: in_valid && in_ready at a rising edge.
- Take event: out_valid && out_ready at a rising edge.
- Extension rules (combinational on the input, captured on accept):
  - sign: upper DATA_WIDTH-IMM_WIDTH bits = immediate[IMM_WIDTH-1]; low bits = immediate.
  - zero: upper bits = 0; low bits = immediate.
  - upper: addr = immediate << (DATA_WIDTH-IMM_WIDTH); low bits = 0.
  - branch: sign-extended value << BR_SHIFT. Bits shifted past DATA_WIDTH-1 are discarded. The low BR_SHIFT bits are 0.
- Latency: 1 cycle, accept edge to out_valid high, when the pipeline is empty.
- Throughput: 1 result per cycle while out_ready stays high.
- State machine (registered; in_ready is a registered output, 1 in EMPTY and FULL, 0 in SKID):
  - EMPTY:
    - accept -> FULL; output register loads the result.
    - otherwise stay in EMPTY.
  - FULL:
    - accept && take -> FULL; output register loads the new result.
    - accept && !take -> SKID; the new result goes to the skid register and the output register holds.
    - take && !accept -> EMPTY; out_valid goes to 0.
    - neither -> hold.
  - SKID:
    - take -> FULL; output register loads the skid contents and the skid entry is cleared.
    - no take -> hold; in_ready stays 0.
- Output stability: while out_valid=1 and out_ready=0, addr and out_mode must not change.
- Ordering: results leave strictly in acceptance order.
- in_valid while in_ready=0 is ignored. Upstream must hold its data.
- No X propagation: addr is 0 whenever out_valid=0 after an EMPTY transition.

Test Plan:
1. Reset then sign mode, immediate=16'h8004, out_ready=1 -> one cycle later out_valid=1, addr=32'hFFFF8004, out_mode=00.
2. Zero mode 16'h8004 -> addr=32'h00008004. Upper mode 16'h1234 -> addr=32'h12340000.
3. Branch mode with BR_SHIFT=2: 16'hFFFF -> addr=32'hFFFFFFFC; 16'h7FFF -> addr=32'h0001FFFC.
4. Back-to-back stream of immediates 1,2,3 with out_ready low for 2 cycles:
   - after the second accept, in_ready=0 and addr holds 1;
   - on release, the outputs appear as 1,2,3 in order with no loss or duplication.
5. Assert rst asynchronously, mid-cycle, while in SKID -> out_valid=0, addr=0, in_ready=1 immediately. The next accept yields a single clean result.
6. Parameter sweep DATA_WIDTH=64, IMM_WIDTH=16, sign mode 16'hF000 -> addr=64'hFFFFFFFFFFFFF000; upper mode -> 64'hF000000000000000.

Source files
------------

// File: rtl/imm_extend_pipe.sv
// imm_extend_pipe: registered immediate-extension stage between decode and execute.
// Widens an IMM_WIDTH immediate to DATA_WIDTH in sign / zero / upper / branch mode.
// Latency 1 cycle when empty; a 2-entry (output + skid) buffer absorbs one stall
// cycle, so a downstream stall never drops or duplicates a result.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous reset, active-high
//   in_valid   upstream presents immediate + mode
//   in_ready   registered; 1 when an input can be accepted this cycle
//   immediate  raw IMM_WIDTH immediate field
//   mode       00 sign, 01 zero, 10 upper, 11 branch
//   out_valid  addr/out_mode hold a valid result
//   out_ready  downstream consumes addr this cycle
//   addr       extended DATA_WIDTH result (0 when empty)
//   out_mode   mode that produced the current addr
module imm_extend_pipe #(
  parameter int DATA_WIDTH = 32,
  parameter int IMM_WIDTH  = 16,
  parameter int BR_SHIFT   = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [IMM_WIDTH-1:0]  immediate,
  input  logic [1:0]            mode,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] addr,
  output logic [1:0]            out_mode
);

  localparam int EXT_W = DATA_WIDTH - IMM_WIDTH;

  localparam logic [1:0] MODE_SIGN   = 2'b00;
  localparam logic [1:0] MODE_ZERO   = 2'b01;
  localparam logic [1:0] MODE_UPPER  = 2'b10;
  localparam logic [1:0] MODE_BRANCH = 2'b11;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_FULL  = 2'b01,
    ST_SKID  = 2'b10
  } state_t;

  state_t state, state_nxt;

  // ---------------------------------------------------------------------------
  // Extension datapath (purely combinational on the input side)
  // ---------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] sext;
  logic [DATA_WIDTH-1:0] zext;
  logic [DATA_WIDTH-1:0] uext;
  logic [DATA_WIDTH-1:0] bext;
  logic [DATA_WIDTH-1:0] ext_res;

  assign sext = {{EXT_W{immediate[IMM_WIDTH-1]}}, immediate};
  assign zext = {{EXT_W{1'b0}}, immediate};
  assign uext = {immediate, {EXT_W{1'b0}}};
  // Bits pushed past the MSB simply fall off the fixed-width vector.
  assign bext = sext << BR_SHIFT;

  always_comb begin
    ext_res = sext;
    case (mode)
      MODE_SIGN:   ext_res = sext;
      MODE_ZERO:   ext_res = zext;
      MODE_UPPER:  ext_res = uext;
      MODE_BRANCH: ext_res = bext;
      default:     ext_res = sext;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Handshake events
  // ---------------------------------------------------------------------------
  logic accept;
  logic take;

  assign accept = in_valid && in_ready;
  assign take   = out_valid && out_ready;

  // ---------------------------------------------------------------------------
  // Next-state and datapath control
  // ---------------------------------------------------------------------------
  logic load_out;    // output register <- freshly extended input
  logic load_skid;   // skid register   <- freshly extended input
  logic promote;     // output register <- skid register
  logic clr_out;     // output register <- 0 (pipeline drained)
  logic clr_skid;    // skid register   <- 0

  always_comb begin
    state_nxt = state;
    load_out  = 1'b0;
    load_skid = 1'b0;
    promote   = 1'b0;
    clr_out   = 1'b0;
    clr_skid  = 1'b0;
    case (state)
      ST_EMPTY: begin
        if (accept) begin
          state_nxt = ST_FULL;
          load_out  = 1'b1;
        end
      end
      ST_FULL: begin
        if (accept && take) begin
          load_out = 1'b1;
        end else if (accept) begin
          // Downstream stalled: park the new result, keep addr stable.
          state_nxt = ST_SKID;
          load_skid = 1'b1;
        end else if (take) begin
          state_nxt = ST_EMPTY;
          clr_out   = 1'b1;
        end
      end
      ST_SKID: begin
        // in_ready is 0 here, so no accept can coincide with the take.
        if (take) begin
          state_nxt = ST_FULL;
          promote   = 1'b1;
          clr_skid  = 1'b1;
        end
      end
      default: begin
        state_nxt = ST_EMPTY;
        clr_out   = 1'b1;
        clr_skid  = 1'b1;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State register plus registered handshake outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_EMPTY;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      state     <= state_nxt;
      out_valid <= (state_nxt != ST_EMPTY);
      // Registered ready: only the SKID state (both entries occupied) blocks input.
      in_ready  <= (state_nxt != ST_SKID);
    end
  end

  // ---------------------------------------------------------------------------
  // Output and skid registers
  // ---------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] skid_addr;
  logic [1:0]            skid_mode;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr     <= '0;
      out_mode <= 2'b00;
    end else if (load_out) begin
      addr     <= ext_res;
      out_mode <= mode;
    end else if (promote) begin
      addr     <= skid_addr;
      out_mode <= skid_mode;
    end else if (clr_out) begin
      // Drained: force a clean zero so no stale value is visible.
      addr     <= '0;
      out_mode <= 2'b00;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      skid_addr <= '0;
      skid_mode <= 2'b00;
    end else if (load_skid) begin
      skid_addr <= ext_res;
      skid_mode <= mode;
    end else if (clr_skid) begin
      skid_addr <= '0;
      skid_mode <= 2'b00;
    end
  end

endmodule

// File: tb/tb_imm_extend_pipe.sv
module tb_imm_extend_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  // 32-bit default instance
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [15:0] immediate;
  logic [1:0]  mode, out_mode;
  logic [31:0] addr;

  // 64-bit instance
  logic        in_valid64, in_ready64, out_valid64, out_ready64;
  logic [15:0] immediate64;
  logic [1:0]  mode64, out_mode64;
  logic [63:0] addr64;

  imm_extend_pipe #(.DATA_WIDTH(32), .IMM_WIDTH(16), .BR_SHIFT(2)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .immediate(immediate), .mode(mode),
    .out_valid(out_valid), .out_ready(out_ready),
    .addr(addr), .out_mode(out_mode)
  );

  imm_extend_pipe #(.DATA_WIDTH(64), .IMM_WIDTH(16), .BR_SHIFT(2)) dut64 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid64), .in_ready(in_ready64),
    .immediate(immediate64), .mode(mode64),
    .out_valid(out_valid64), .out_ready(out_ready64),
    .addr(addr64), .out_mode(out_mode64)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: the extension rules as plain two's-complement arithmetic.
  function automatic logic [63:0] ref_ext(input int dw, input int iw, input int sh,
                                          input logic [1:0] m, input logic [63:0] imm);
    logic [63:0] mask, s, r;
    mask = (dw == 64) ? '1 : ((64'd1 << dw) - 64'd1);
    s = imm;
    if (imm >= (64'd1 << (iw - 1))) s = imm - (64'd1 << iw);
    case (m)
      2'b00:   r = s;
      2'b01:   r = imm;
      2'b10:   r = imm * (64'd1 << (dw - iw));
      default: r = s * (64'd1 << sh);
    endcase
    return r & mask;
  endfunction

  typedef struct {
    logic [1:0]  m;
    logic [15:0] imm;
    logic [31:0] exp;
  } vec_t;

  typedef struct {
    logic [1:0]  m;
    logic [15:0] imm;
    logic [63:0] exp;
  } vec64_t;

  vec_t   vecs[8];
  vec64_t vecs64[3];

  logic [31:0] exp_a[$];
  logic [1:0]  exp_m[$];
  logic [31:0] got[$];

  initial begin
    logic        do_push, do_pop, sent3;
    logic [31:0] push_a;
    logic [1:0]  push_m;

    vecs[0] = '{2'b00, 16'h8004, 32'hFFFF8004};
    vecs[1] = '{2'b01, 16'h8004, 32'h00008004};
    vecs[2] = '{2'b10, 16'h1234, 32'h12340000};
    vecs[3] = '{2'b11, 16'hFFFF, 32'hFFFFFFFC};
    vecs[4] = '{2'b11, 16'h7FFF, 32'h0001FFFC};
    vecs[5] = '{2'b00, 16'h7FFF, 32'h00007FFF};
    vecs[6] = '{2'b10, 16'hFFFF, 32'hFFFF0000};
    vecs[7] = '{2'b11, 16'h8000, 32'hFFFE0000};

    vecs64[0] = '{2'b00, 16'hF000, 64'hFFFFFFFFFFFFF000};
    vecs64[1] = '{2'b10, 16'hF000, 64'hF000000000000000};
    vecs64[2] = '{2'b11, 16'hF000, 64'hFFFFFFFFFFFFC000};

    rst = 1'b1;
    in_valid = 1'b0; immediate = '0; mode = 2'b00; out_ready = 1'b1;
    in_valid64 = 1'b0; immediate64 = '0; mode64 = 2'b00; out_ready64 = 1'b1;

    // Reset state
    #12;
    chk("reset_out_valid", out_valid, 0);
    chk("reset_addr", addr, 0);
    chk("reset_out_mode", out_mode, 0);
    chk("reset_in_ready", in_ready, 1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("post_reset_out_valid", out_valid, 0);

    // Directed table: one transaction at a time, out_ready high.
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      in_valid = 1'b1; immediate = vecs[i].imm; mode = vecs[i].m;
      @(negedge clk);
      in_valid = 1'b0;
      chk($sformatf("vec%0d_out_valid", i), out_valid, 1);
      chk($sformatf("vec%0d_addr", i), addr, vecs[i].exp);
      chk($sformatf("vec%0d_out_mode", i), out_mode, vecs[i].m);
      @(negedge clk);
      chk($sformatf("vec%0d_drained", i), out_valid, 0);
      chk($sformatf("vec%0d_addr_zero", i), addr, 0);
    end

    // Stall sequence: 1,2 accepted while out_ready low, then 3 after release.
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1; mode = 2'b01; immediate = 16'd1;
    @(negedge clk);
    immediate = 16'd2;
    @(negedge clk);
    immediate = 16'd3;
    chk("stall_in_ready", in_ready, 0);
    chk("stall_addr_holds", addr, 1);
    chk("stall_out_valid", out_valid, 1);
    out_ready = 1'b1;
    sent3 = 1'b0;
    got.delete();
    for (int k = 0; k < 10; k++) begin
      if (k > 0) @(negedge clk);
      if (sent3) in_valid = 1'b0;
      if (out_valid && out_ready) got.push_back(addr);
      if (in_valid && in_ready) sent3 = 1'b1;
      if (got.size() == 3) break;
    end
    in_valid = 1'b0;
    chk("order_count", got.size(), 3);
    for (int k = 0; k < 3; k++)
      chk($sformatf("order_item%0d", k), (k < got.size()) ? got[k] : 32'hDEAD, k + 1);
    @(negedge clk);
    chk("order_no_dup", out_valid, 0);

    // Asynchronous reset while in SKID.
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1; mode = 2'b01; immediate = 16'd5;
    @(negedge clk);
    immediate = 16'd6;
    @(negedge clk);
    in_valid = 1'b0;
    chk("skid_before_reset", in_ready, 0);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_out_valid", out_valid, 0);
    chk("async_rst_addr", addr, 0);
    chk("async_rst_in_ready", in_ready, 1);
    chk("async_rst_out_mode", out_mode, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    in_valid = 1'b1; mode = 2'b00; immediate = 16'd7; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    chk("post_rst_valid", out_valid, 1);
    chk("post_rst_addr", addr, 7);
    @(negedge clk);
    chk("post_rst_single", out_valid, 0);

    // 64-bit instance.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_valid64 = 1'b1; immediate64 = vecs64[i].imm; mode64 = vecs64[i].m;
      @(negedge clk);
      in_valid64 = 1'b0;
      chk($sformatf("w64_%0d_valid", i), out_valid64, 1);
      chk($sformatf("w64_%0d_addr", i), addr64, vecs64[i].exp);
      chk($sformatf("w64_%0d_model", i), addr64, ref_ext(64, 16, 2, vecs64[i].m, {48'd0, vecs64[i].imm}));
      @(negedge clk);
    end

    // Randomized traffic against a queue model (capacity 2).
    exp_a.delete(); exp_m.delete();
    do_push = 1'b0; do_pop = 1'b0;
    push_a = '0; push_m = '0;
    in_valid = 1'b0; out_ready = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (do_pop && exp_a.size() > 0) begin
        void'(exp_a.pop_front());
        void'(exp_m.pop_front());
      end
      if (do_push) begin
        exp_a.push_back(push_a);
        exp_m.push_back(push_m);
      end
      checks++;
      if (out_valid !== (exp_a.size() > 0) || in_ready !== (exp_a.size() < 2)) begin
        failures++;
        $display("FAIL rand_hs cycle %0d: out_valid=%b in_ready=%b expected depth %0d",
                 c, out_valid, in_ready, exp_a.size());
      end
      if (exp_a.size() > 0) begin
        chk($sformatf("rand_addr_c%0d", c), addr, exp_a[0]);
        chk($sformatf("rand_mode_c%0d", c), out_mode, exp_m[0]);
      end else begin
        chk($sformatf("rand_idle_addr_c%0d", c), addr, 0);
      end
      // Upstream holds a presented-but-unaccepted item.
      if (!(in_valid && !do_push)) begin
        in_valid  = ($urandom_range(0, 9) < 7);
        immediate = 16'($urandom);
        mode      = 2'($urandom);
      end
      out_ready = (c % 400 < 200) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      do_push = in_valid && in_ready;
      do_pop  = out_valid && out_ready;
      push_a  = ref_ext(32, 16, 2, mode, {48'd0, immediate})[31:0];
      push_m  = mode;
    end
    in_valid = 1'b0;
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
